fifo_stream_reader: RTL

//  Read-side controller for synchronous_fifo-style buffers. Issues read_en against the FIFO's

---
 rtl/fifo_skid_buffer.sv | 96 +++++++++
 rtl/fifo_stream_reader.sv | 88 ++++++++
 2 files changed

// File: rtl/fifo_skid_buffer.sv
// Two-entry FIFO-ordered register buffer with push, pop and synchronous clear.
// The head word and the valid flag are kept in dedicated flops so downstream sees registered outputs.
module fifo_skid_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [1:0]            occ,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = 2;

  logic [DATA_WIDTH-1:0] mem_r [BUF_DEPTH];
  logic                  head_ptr_r;
  logic                  tail_ptr_r;
  logic [OCC_W-1:0]      occ_r;
  logic [OCC_W-1:0]      occ_nxt_s;
  logic                  valid_r;
  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] head_nxt_s;

  // next occupancy: clear wins, simultaneous push and pop leaves it unchanged
  always_comb begin
    occ_nxt_s = occ_r;
    if (clear) begin
      occ_nxt_s = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   occ_nxt_s = occ_r + 2'd1;
        2'b01:   occ_nxt_s = occ_r - 2'd1;
        default: occ_nxt_s = occ_r;
      endcase
    end
  end

  // next head word: the other entry after a pop from full, or the incoming word when it lands at the head
  always_comb begin
    head_nxt_s = head_r;
    if (clear) begin
      head_nxt_s = head_r;
    end else if (pop && (occ_r == 2'd2)) begin
      head_nxt_s = mem_r[~head_ptr_r];
    end else if (push && ((occ_r == 2'd0) || (pop && (occ_r == 2'd1)))) begin
      head_nxt_s = din;
    end else begin
      head_nxt_s = head_r;
    end
  end

  // storage and pointer update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      head_ptr_r <= 1'b0;
      tail_ptr_r <= 1'b0;
    end else if (clear) begin
      head_ptr_r <= 1'b0;
      tail_ptr_r <= 1'b0;
    end else begin
      if (push) begin
        mem_r[tail_ptr_r] <= din;
        tail_ptr_r        <= ~tail_ptr_r;
      end
      if (pop) begin
        head_ptr_r <= ~head_ptr_r;
      end
    end
  end

  // occupancy, valid flag and head word registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_r   <= 2'd0;
      valid_r <= 1'b0;
      head_r  <= '0;
    end else begin
      occ_r   <= occ_nxt_s;
      valid_r <= (occ_nxt_s != 2'd0);
      head_r  <= head_nxt_s;
    end
  end

  assign occ   = occ_r;
  assign valid = valid_r;
  assign head  = head_r;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller for a synchronous FIFO: issues reads, captures the registered read data
// one cycle later and presents it as a valid/ready stream through a two-entry buffer.
module fifo_stream_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_rd_en,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  input  logic                   flush,
  output logic [COUNT_WIDTH-1:0] word_count
);

  localparam int OCC_W = 2;

  logic [OCC_W-1:0]       occ_s;
  logic [OCC_W-1:0]       load_s;
  logic                   inflight_r;
  logic                   pop_s;
  logic                   capture_s;
  logic                   rd_en_s;
  logic                   valid_s;
  logic [DATA_WIDTH-1:0]  head_s;
  logic [COUNT_WIDTH-1:0] word_count_r;

  assign pop_s     = valid_s & m_ready;
  assign capture_s = inflight_r & ~flush;
  assign load_s    = occ_s + {1'b0, inflight_r};

  // read issue: only when a slot is guaranteed, counting a slot freed by this cycle's pop
  always_comb begin
    rd_en_s = 1'b0;
    if (!reset_n || fifo_empty || flush) begin
      rd_en_s = 1'b0;
    end else if (load_s < 2'd2) begin
      rd_en_s = 1'b1;
    end else if ((load_s == 2'd2) && pop_s) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // in-flight flag tracks last cycle's read strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= rd_en_s;
    end
  end

  // delivered-word counter, a pop in a flush cycle still counts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_count_r <= '0;
    end else if (pop_s) begin
      word_count_r <= word_count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      word_count_r <= word_count_r;
    end
  end

  fifo_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .push    (capture_s),
    .pop     (pop_s),
    .din     (fifo_data),
    .occ     (occ_s),
    .valid   (valid_s),
    .head    (head_s)
  );

  assign fifo_rd_en = rd_en_s;
  assign m_valid    = valid_s;
  assign m_data     = head_s;
  assign word_count = word_count_r;

endmodule
